// File: rtl/pc_sequencer.sv
// Program counter and sequencer: steps through a table of program entry points,
// executes branches, CALL/RET via a return stack, and halts on request or stack error.
module pc_sequencer #(
    parameter  int PCW         = 16,
    parameter  int NUM_PROGS   = 4,
    parameter  int STACK_DEPTH = 4,
    parameter  int OFFW        = 8,
    localparam int PIDW        = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    localparam int SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic [NUM_PROGS*PCW-1:0] START_ADDRS,
    input  logic                     HALT,
    input  logic                     BR_ABS,
    input  logic                     BR_REL,
    input  logic                     ZERO,
    input  logic                     CALL,
    input  logic                     RET,
    input  logic [PCW-1:0]           TARGET,
    input  logic [OFFW-1:0]          OFFSET,
    output logic [PCW-1:0]           PC,
    output logic [PIDW-1:0]          PROG_ID,
    output logic                     DONE,
    output logic                     ERR,
    output logic [SPW-1:0]           STACK_LVL
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALTED} state_t;

    state_t          state_q;
    logic [PCW-1:0]  pc_q;
    logic [PIDW-1:0] prog_id_q;
    logic [PIDW-1:0] nxt_q;
    logic [SPW-1:0]  sp_q;
    logic            done_q;
    logic            err_q;
    logic            start_q;

    // Padded to a power of two so the SP register indexes it without width mismatch.
    logic [PCW-1:0]  stack_q [2**SPW];

    logic signed [PCW-1:0] off_ext_d;
    logic [PCW-1:0]        pc_inc_d;
    logic [PCW-1:0]        pc_rel_d;
    logic [PIDW-1:0]       nxt_inc_d;
    logic [SPW-1:0]        sp_m1_d;
    logic                  push_d;

    assign off_ext_d = PCW'($signed(OFFSET));
    assign pc_inc_d  = pc_q + PCW'(1);
    assign pc_rel_d  = pc_q + $unsigned(off_ext_d);
    assign nxt_inc_d = (nxt_q == PIDW'(NUM_PROGS - 1)) ? '0 : nxt_q + PIDW'(1);
    assign sp_m1_d   = sp_q - SPW'(1);
    assign push_d    = (state_q == S_RUN) && !START && !HALT && !RET && CALL &&
                       (sp_q < SPW'(STACK_DEPTH));

    always_ff @(posedge CLK) begin
        if (push_d) begin
            stack_q[sp_q] <= pc_inc_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            prog_id_q <= '0;
            nxt_q     <= '0;
            sp_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= START;
            if (START) begin
                state_q   <= S_LOAD;
                pc_q      <= START_ADDRS[nxt_q*PCW +: PCW];
                prog_id_q <= nxt_q;
                sp_q      <= '0;
                err_q     <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        // Falling edge of START releases execution from the entry address.
                        if (start_q) begin
                            state_q <= S_RUN;
                            nxt_q   <= nxt_inc_d;
                        end
                    end
                    S_RUN: begin
                        if (HALT) begin
                            state_q <= S_HALTED;
                            done_q  <= 1'b1;
                        end else if (RET) begin
                            if (sp_q != '0) begin
                                pc_q <= stack_q[sp_m1_d];
                                sp_q <= sp_m1_d;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= S_HALTED;
                                done_q  <= 1'b1;
                            end
                        end else if (CALL) begin
                            if (push_d) begin
                                pc_q <= TARGET;
                                sp_q <= sp_q + SPW'(1);
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= S_HALTED;
                                done_q  <= 1'b1;
                            end
                        end else if (BR_ABS && ZERO) begin
                            pc_q <= TARGET;
                        end else if (BR_REL && ZERO) begin
                            pc_q <= pc_rel_d;
                        end else begin
                            pc_q <= pc_inc_d;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign PC        = pc_q;
    assign PROG_ID   = prog_id_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign STACK_LVL = sp_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: entry stepping, branches, call/return,
// stack errors, priority/wrap and asynchronous reset.
module tb_pc_sequencer;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [63:0] START_ADDRS;
    logic        HALT, BR_ABS, BR_REL, ZERO, CALL, RET;
    logic [15:0] TARGET;
    logic [7:0]  OFFSET;
    logic [15:0] PC;
    logic [1:0]  PROG_ID;
    logic        DONE, ERR;
    logic [2:0]  STACK_LVL;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.PCW(16), .NUM_PROGS(4), .STACK_DEPTH(4), .OFFW(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .START_ADDRS(START_ADDRS),
        .HALT(HALT), .BR_ABS(BR_ABS), .BR_REL(BR_REL), .ZERO(ZERO),
        .CALL(CALL), .RET(RET), .TARGET(TARGET), .OFFSET(OFFSET),
        .PC(PC), .PROG_ID(PROG_ID), .DONE(DONE), .ERR(ERR), .STACK_LVL(STACK_LVL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ctl();
        HALT = 0; BR_ABS = 0; BR_REL = 0; ZERO = 0; CALL = 0; RET = 0;
        TARGET = '0; OFFSET = '0;
    endtask

    // One-cycle START pulse; returns with the DUT in RUN and PC at the entry address.
    task automatic pulse_start();
        START = 1; tick();
        START = 0; tick();
    endtask

    task automatic load_at(input logic [15:0] addr);
        START_ADDRS = {4{addr}};
        pulse_start();
    endtask

    task automatic test_reset();
        RST_N = 0; START = 0; START_ADDRS = '0; clear_ctl();
        tick(); tick();
        n_checks++; if (PC !== 16'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", PC); end
        n_checks++; if (PROG_ID !== 2'd0) begin n_fail++; $display("FAIL reset_prog_id: got %0d expected 0", PROG_ID); end
        n_checks++; if ({DONE, ERR} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b expected 00", {DONE, ERR}); end
        n_checks++; if (STACK_LVL !== 3'd0) begin n_fail++; $display("FAIL reset_stack_lvl: got %0d expected 0", STACK_LVL); end
        #2 RST_N = 1;
        tick();
        n_checks++; if (PC !== 16'd0) begin n_fail++; $display("FAIL idle_pc_hold: got %0d expected 0", PC); end
    endtask

    task automatic test_entry_stepping();
        logic [15:0] exp_pc [5];
        logic [1:0]  exp_id [5];
        exp_pc = '{16'd0, 16'd10, 16'd29, 16'd40, 16'd0};
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        START_ADDRS = {16'd40, 16'd29, 16'd10, 16'd0};
        for (int k = 0; k < 5; k++) begin
            pulse_start();
            n_checks++; if (PC !== exp_pc[k]) begin n_fail++; $display("FAIL entry_pc[%0d]: got %0d expected %0d", k, PC, exp_pc[k]); end
            n_checks++; if (PROG_ID !== exp_id[k]) begin n_fail++; $display("FAIL entry_prog_id[%0d]: got %0d expected %0d", k, PROG_ID, exp_id[k]); end
            n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL entry_done_clear[%0d]: got %b expected 0", k, DONE); end
            tick();
            n_checks++; if (PC !== exp_pc[k] + 16'd1) begin n_fail++; $display("FAIL entry_pc_p1[%0d]: got %0d expected %0d", k, PC, exp_pc[k] + 16'd1); end
            tick();
            n_checks++; if (PC !== exp_pc[k] + 16'd2) begin n_fail++; $display("FAIL entry_pc_p2[%0d]: got %0d expected %0d", k, PC, exp_pc[k] + 16'd2); end
            HALT = 1; tick(); HALT = 0;
            n_checks++; if (DONE !== 1'b1) begin n_fail++; $display("FAIL entry_done[%0d]: got %b expected 1", k, DONE); end
            tick();
            n_checks++; if (PC !== exp_pc[k] + 16'd2) begin n_fail++; $display("FAIL halted_pc_hold[%0d]: got %0d expected %0d", k, PC, exp_pc[k] + 16'd2); end
        end
    endtask

    task automatic test_branches();
        load_at(16'd20);
        BR_REL = 1; OFFSET = 8'hFB; ZERO = 1; tick(); clear_ctl();
        n_checks++; if (PC !== 16'd15) begin n_fail++; $display("FAIL br_rel_neg: got %0d expected 15", PC); end
        BR_ABS = 1; TARGET = 16'd100; ZERO = 0; tick(); clear_ctl();
        n_checks++; if (PC !== 16'd16) begin n_fail++; $display("FAIL br_abs_not_taken: got %0d expected 16", PC); end
        BR_ABS = 1; TARGET = 16'd100; ZERO = 1; tick(); clear_ctl();
        n_checks++; if (PC !== 16'd100) begin n_fail++; $display("FAIL br_abs_taken: got %0d expected 100", PC); end
        tick();
        n_checks++; if (PC !== 16'd101) begin n_fail++; $display("FAIL after_branch_inc: got %0d expected 101", PC); end
    endtask

    task automatic test_call_return();
        load_at(16'd7);
        CALL = 1; TARGET = 16'd50; tick(); clear_ctl();
        n_checks++; if (PC !== 16'd50 || STACK_LVL !== 3'd1) begin n_fail++; $display("FAIL call1: got pc=%0d lvl=%0d expected pc=50 lvl=1", PC, STACK_LVL); end
        tick(); tick();
        n_checks++; if (PC !== 16'd52) begin n_fail++; $display("FAIL call1_run: got %0d expected 52", PC); end
        CALL = 1; TARGET = 16'd60; tick(); clear_ctl();
        n_checks++; if (PC !== 16'd60 || STACK_LVL !== 3'd2) begin n_fail++; $display("FAIL call2: got pc=%0d lvl=%0d expected pc=60 lvl=2", PC, STACK_LVL); end
        RET = 1; tick(); clear_ctl();
        n_checks++; if (PC !== 16'd53 || STACK_LVL !== 3'd1) begin n_fail++; $display("FAIL ret1: got pc=%0d lvl=%0d expected pc=53 lvl=1", PC, STACK_LVL); end
        RET = 1; tick(); clear_ctl();
        n_checks++; if (PC !== 16'd8 || STACK_LVL !== 3'd0) begin n_fail++; $display("FAIL ret2: got pc=%0d lvl=%0d expected pc=8 lvl=0", PC, STACK_LVL); end
    endtask

    task automatic test_stack_errors();
        load_at(16'd0);
        for (int k = 1; k <= 4; k++) begin
            CALL = 1; TARGET = 16'd200; tick(); clear_ctl();
            n_checks++; if (STACK_LVL !== 3'(k) || ERR !== 1'b0) begin n_fail++; $display("FAIL push[%0d]: got lvl=%0d err=%b expected lvl=%0d err=0", k, STACK_LVL, ERR, k); end
        end
        CALL = 1; TARGET = 16'd300; tick(); clear_ctl();
        n_checks++; if ({ERR, DONE} !== 2'b11) begin n_fail++; $display("FAIL overflow_flags: got err/done=%b expected 11", {ERR, DONE}); end
        n_checks++; if (PC !== 16'd200 || STACK_LVL !== 3'd4) begin n_fail++; $display("FAIL overflow_state: got pc=%0d lvl=%0d expected pc=200 lvl=4", PC, STACK_LVL); end
        tick();
        n_checks++; if (PC !== 16'd200 || ERR !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got pc=%0d err=%b expected pc=200 err=1", PC, ERR); end
        pulse_start();
        n_checks++; if ({ERR, DONE} !== 2'b00 || STACK_LVL !== 3'd0) begin n_fail++; $display("FAIL start_clears_err: got err/done=%b lvl=%0d expected 00 lvl=0", {ERR, DONE}, STACK_LVL); end
        RET = 1; tick(); clear_ctl();
        n_checks++; if ({ERR, DONE} !== 2'b11 || PC !== 16'd0) begin n_fail++; $display("FAIL underflow: got err/done=%b pc=%0d expected 11 pc=0", {ERR, DONE}, PC); end
        pulse_start();
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL start_clears_underflow: got %b expected 0", ERR); end
    endtask

    task automatic test_priority_wrap();
        load_at(16'd30);
        CALL = 1; TARGET = 16'd70; tick(); clear_ctl();
        HALT = 1; CALL = 1; BR_ABS = 1; ZERO = 1; TARGET = 16'd5; tick(); clear_ctl();
        n_checks++; if (DONE !== 1'b1 || PC !== 16'd70 || STACK_LVL !== 3'd1) begin n_fail++; $display("FAIL halt_priority: got done=%b pc=%0d lvl=%0d expected done=1 pc=70 lvl=1", DONE, PC, STACK_LVL); end
        load_at(16'hFFFF);
        tick();
        n_checks++; if (PC !== 16'h0000) begin n_fail++; $display("FAIL pc_wrap: got %h expected 0000", PC); end
        load_at(16'h0002);
        BR_REL = 1; OFFSET = 8'hFC; ZERO = 1; tick(); clear_ctl();
        n_checks++; if (PC !== 16'hFFFE) begin n_fail++; $display("FAIL rel_wrap: got %h expected fffe", PC); end
    endtask

    task automatic test_async_reset();
        load_at(16'd30);
        CALL = 1; TARGET = 16'd90; tick(); clear_ctl();
        tick();
        #2 RST_N = 0;
        #1;
        n_checks++; if (PC !== 16'd0 || STACK_LVL !== 3'd0) begin n_fail++; $display("FAIL async_reset_pc_lvl: got pc=%0d lvl=%0d expected 0 0", PC, STACK_LVL); end
        n_checks++; if ({DONE, ERR} !== 2'b00 || PROG_ID !== 2'd0) begin n_fail++; $display("FAIL async_reset_flags: got done/err=%b id=%0d expected 00 id=0", {DONE, ERR}, PROG_ID); end
        tick();
        RST_N = 1;
        START_ADDRS = {16'd40, 16'd29, 16'd10, 16'd7};
        pulse_start();
        n_checks++; if (PC !== 16'd7 || PROG_ID !== 2'd0) begin n_fail++; $display("FAIL post_reset_entry: got pc=%0d id=%0d expected pc=7 id=0", PC, PROG_ID); end
        tick();
        n_checks++; if (PC !== 16'd8) begin n_fail++; $display("FAIL post_reset_run: got %0d expected 8", PC); end
    endtask

    initial begin
        test_reset();
        test_entry_stepping();
        test_branches();
        test_call_return();
        test_stack_errors();
        test_priority_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
